// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_pkg
// Brief  : Shared types and byte-merge helper for dual_port_ram_clr.
// Rev    : 1.0
// ============================================================================
package ram_pkg;

    typedef enum logic {ST_CLEAR, ST_IDLE} ram_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic [7:0] be_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_clr_seq.sv
`default_nettype none
// ============================================================================
// Module : ram_clr_seq
// Brief  : Clear sequencer; owns the FSM, clear pointer and the write-port mux.
// Rev    : 1.0
// ============================================================================
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int                DWIDTH   = 16,
    parameter int                AWIDTH   = 8,
    parameter logic [DWIDTH-1:0] INIT_VAL = '1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_clr_req,
    input  logic                i_wr_en,
    input  logic [AWIDTH-1:0]   i_wr_addr,
    input  logic [DWIDTH/8-1:0] i_wr_be,
    input  logic [DWIDTH-1:0]   i_wr_data,
    output logic                o_busy,
    output logic                o_mem_we,
    output logic [AWIDTH-1:0]   o_mem_addr,
    output logic [DWIDTH/8-1:0] o_mem_be,
    output logic [DWIDTH-1:0]   o_mem_data
);

    localparam logic [AWIDTH-1:0] c_LAST_ADDR = '1;

    ram_state_t        r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_clr_ptr, w_clr_ptr_nxt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // While clearing, the user write port is replaced by the clear write.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        o_busy        = 1'b0;
        o_mem_we      = i_wr_en;
        o_mem_addr    = i_wr_addr;
        o_mem_be      = i_wr_be;
        o_mem_data    = i_wr_data;
        case (r_state)
            ST_CLEAR: begin
                o_busy        = 1'b1;
                o_mem_we      = 1'b1;
                o_mem_addr    = r_clr_ptr;
                o_mem_be      = '1;
                o_mem_data    = INIT_VAL;
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_clr.sv
`default_nettype none
// ============================================================================
// Module : dual_port_ram_clr
// Brief  : Simple-dual-port RAM with byte enables, RD_LAT 1/2, RDW policy and
//          self-clear. Optional per-byte parity with macro RAM_PARITY_EN.
// Rev    : 1.0
// ============================================================================
module dual_port_ram_clr
    import ram_pkg::*;
#(
    parameter int                DWIDTH   = 16,
    parameter int                AWIDTH   = 8,
    parameter int                RD_LAT   = 1,
    parameter int                RDW_MODE = 0,
    parameter logic [DWIDTH-1:0] INIT_VAL = '1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                wr_en,
    input  logic [AWIDTH-1:0]   wr_addr,
    input  logic [DWIDTH/8-1:0] wr_be,
    input  logic [DWIDTH-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [AWIDTH-1:0]   rd_addr,
    output logic [DWIDTH-1:0]   rd_data,
    output logic                rd_valid
`ifdef RAM_PARITY_EN
    ,
    output logic                par_err
`endif
);

    localparam int c_NB    = DWIDTH / 8;
    localparam int c_DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] r_mem [c_DEPTH];

    logic              w_busy, w_mem_we;
    logic [AWIDTH-1:0] w_mem_addr;
    logic [c_NB-1:0]   w_mem_be;
    logic [DWIDTH-1:0] w_mem_data;

    ram_clr_seq #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .INIT_VAL (INIT_VAL)
    ) u_clr_seq (
        .clk        (clk),
        .nrst       (nrst),
        .i_clr_req  (clr_req),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_be    (wr_be),
        .i_wr_data  (wr_data),
        .o_busy     (w_busy),
        .o_mem_we   (w_mem_we),
        .o_mem_addr (w_mem_addr),
        .o_mem_be   (w_mem_be),
        .o_mem_data (w_mem_data)
    );

    assign busy = w_busy;

    logic [DWIDTH-1:0] w_wr_old, w_wr_word, w_rd_old, w_rd_word;
    logic              w_rd_fire, w_bypass;

    assign w_wr_old  = r_mem[w_mem_addr];
    assign w_rd_old  = r_mem[rd_addr];
    assign w_rd_fire = rd_en & ~w_busy;
    assign w_bypass  = (RDW_MODE == RDW_NEW) && wr_en && !w_busy && (wr_addr == rd_addr);

    always_comb begin
        w_wr_word = w_wr_old;
        w_rd_word = w_rd_old;
        for (int i = 0; i < c_NB; i++) begin
            w_wr_word[8*i +: 8] = be_merge(w_wr_old[8*i +: 8], w_mem_data[8*i +: 8], w_mem_be[i]);
            w_rd_word[8*i +: 8] = be_merge(w_rd_old[8*i +: 8], wr_data[8*i +: 8], wr_be[i] & w_bypass);
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_wr_word;
        end
    end

`ifdef RAM_PARITY_EN
    logic [c_NB-1:0] r_par [c_DEPTH];
    logic [c_NB-1:0] w_wr_old_par, w_rd_old_par, w_wr_par, w_rd_par_bad;
    logic            w_rd_perr;

    assign w_wr_old_par = r_par[w_mem_addr];
    assign w_rd_old_par = r_par[rd_addr];

    always_comb begin
        w_wr_par     = w_wr_old_par;
        w_rd_par_bad = '0;
        for (int i = 0; i < c_NB; i++) begin
            if (w_mem_be[i]) begin
                w_wr_par[i] = ^w_mem_data[8*i +: 8];
            end
            w_rd_par_bad[i] = (^w_rd_old[8*i +: 8]) ^ w_rd_old_par[i];
        end
    end

    assign w_rd_perr = |w_rd_par_bad;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_par[w_mem_addr] <= w_wr_par;
        end
    end
`endif

    logic [DWIDTH-1:0] w_out_data;
    logic              w_out_v;
`ifdef RAM_PARITY_EN
    logic              w_out_perr;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DWIDTH-1:0] r_s1_data;
            logic              r_s1_v;
`ifdef RAM_PARITY_EN
            logic              r_s1_perr;
`endif
            always_ff @(posedge clk) begin
                if (!nrst) begin
                    r_s1_v    <= 1'b0;
                    r_s1_data <= INIT_VAL;
`ifdef RAM_PARITY_EN
                    r_s1_perr <= 1'b0;
`endif
                end else begin
                    r_s1_v    <= w_rd_fire;
                    r_s1_data <= w_rd_word;
`ifdef RAM_PARITY_EN
                    r_s1_perr <= w_rd_perr;
`endif
                end
            end
            assign w_out_data = r_s1_data;
            assign w_out_v    = r_s1_v;
`ifdef RAM_PARITY_EN
            assign w_out_perr = r_s1_perr;
`endif
        end else begin : g_lat1
            assign w_out_data = w_rd_word;
            assign w_out_v    = w_rd_fire;
`ifdef RAM_PARITY_EN
            assign w_out_perr = w_rd_perr;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_data  <= INIT_VAL;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_out_v;
            if (w_out_v) begin
                rd_data <= w_out_data;
            end
        end
    end

`ifdef RAM_PARITY_EN
    // Sticky error; a detection in flight wins over the clear that follows it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            par_err <= 1'b0;
        end else if (w_out_v && w_out_perr) begin
            par_err <= 1'b1;
        end else if (w_busy) begin
            par_err <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_clr.sv
`default_nettype none
// ============================================================================
// Module : tb_dual_port_ram_clr
// Brief  : Two DUTs (RD_LAT=1/old-data, RD_LAT=2/new-data) on shared stimulus,
//          checked every cycle against a behavioural model plus literal checks.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dual_port_ram_clr;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk     = 1'b0;
    logic          nrst    = 1'b0;
    logic          clr_req = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [1:0]    wr_be   = '0;
    logic [DW-1:0] wr_data = '0;

    logic          busy_a, busy_b, rd_valid_a, rd_valid_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
`ifdef RAM_PARITY_EN
    logic          par_err_a, par_err_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_port_ram_clr #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(16'hFFFF)) dut_a (
        .clk(clk), .nrst(nrst), .clr_req(clr_req), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
`ifdef RAM_PARITY_EN
        , .par_err(par_err_a)
`endif
    );

    dual_port_ram_clr #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(16'hFFFF)) dut_b (
        .clk(clk), .nrst(nrst), .clr_req(clr_req), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
`ifdef RAM_PARITY_EN
        , .par_err(par_err_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] d;
        bit            perr;
    } rd_t;

    rd_t           q_a[$];
    rd_t           q_b[$];
    logic [DW-1:0] m_mem [DEPTH];
    logic [1:0]    m_bad [DEPTH];
    bit            m_clearing = 1'b1;
    int            m_ptr      = 0;
    int            cyc        = 0;
    logic [DW-1:0] e_data_a   = 16'hFFFF;
    logic [DW-1:0] e_data_b   = 16'hFFFF;
    bit            e_v_a, e_v_b, e_perr_a, e_perr_b;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    task automatic step_model();
        bit            pre_clear;
        logic [DW-1:0] old;
        bit            pe;
        rd_t           r;
        pre_clear = m_clearing;
        e_v_a = 1'b0;
        e_v_b = 1'b0;
        if (!nrst) begin
            m_clearing = 1'b1;
            m_ptr      = 0;
            q_a.delete();
            q_b.delete();
            e_data_a = 16'hFFFF;
            e_data_b = 16'hFFFF;
            e_perr_a = 1'b0;
            e_perr_b = 1'b0;
            return;
        end
        if (m_clearing) begin
            m_mem[m_ptr] = 16'hFFFF;
            m_bad[m_ptr] = 2'b00;
            m_ptr++;
            if (m_ptr == DEPTH) m_clearing = 1'b0;
        end else begin
            if (rd_en) begin
                old = m_mem[rd_addr];
                pe  = |m_bad[rd_addr];
                q_a.push_back(rd_t'{cyc, old, pe});
                q_b.push_back(rd_t'{cyc + 1, (wr_en && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old, pe});
            end
            if (wr_en) begin
                m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
                m_bad[wr_addr] = m_bad[wr_addr] & ~wr_be;
            end
            if (clr_req) begin
                m_clearing = 1'b1;
                m_ptr      = 0;
            end
        end
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            r = q_a.pop_front();
            e_v_a = 1'b1;
            e_data_a = r.d;
            if (r.perr) e_perr_a = 1'b1;
            else if (pre_clear) e_perr_a = 1'b0;
        end else if (pre_clear) begin
            e_perr_a = 1'b0;
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            r = q_b.pop_front();
            e_v_b = 1'b1;
            e_data_b = r.d;
            if (r.perr) e_perr_b = 1'b1;
            else if (pre_clear) e_perr_b = 1'b0;
        end else if (pre_clear) begin
            e_perr_b = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_bad[i] = 2'b00;
        end
        forever begin
            @(posedge clk);
            cyc++;
            step_model();
            #1;
            check("busy_a", busy_a, m_clearing);
            check("busy_b", busy_b, m_clearing);
            check("valid_a", rd_valid_a, e_v_a);
            check("valid_b", rd_valid_b, e_v_b);
            check("data_a", rd_data_a, e_data_a);
            check("data_b", rd_data_b, e_data_b);
`ifdef RAM_PARITY_EN
            check("perr_a", par_err_a, e_perr_a);
            check("perr_b", par_err_b, e_perr_b);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic reset_count(output int cnt);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        cnt = 0;
        while (busy_a && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [1:0] be, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [15:0] ea, input logic [15:0] eb);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check("lat1_valid_a", rd_valid_a, 1'b1);
        check("lit_data_a", rd_data_a, ea);
        check("lat2_early_b", rd_valid_b, 1'b0);
        @(negedge clk);
        check("lat2_valid_b", rd_valid_b, 1'b1);
        check("lit_data_b", rd_data_b, eb);
        check("lat1_pulse_a", rd_valid_a, 1'b0);
    endtask

    initial begin
        int cnt;
        reset_count(cnt);
        check("clear_len_reset", cnt, 256);
        check("reset_rd_data", rd_data_a, 16'hFFFF);
        do_read(8'h00, 16'hFFFF, 16'hFFFF);
        do_read(8'h7F, 16'hFFFF, 16'hFFFF);
        do_read(8'hFF, 16'hFFFF, 16'hFFFF);

        do_write(8'h10, 2'b01, 16'hA5A5);
        do_read(8'h10, 16'hFFA5, 16'hFFA5);
        do_write(8'h11, 2'b00, 16'h0000);
        do_read(8'h11, 16'hFFFF, 16'hFFFF);

        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'h20; wr_be = 2'b11; wr_data = 16'h1234;
        rd_en = 1'b1; rd_addr = 8'h20;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw_old_a", rd_data_a, 16'hFFFF);
        @(negedge clk);
        check("rdw_new_b", rd_data_b, 16'h1234);
        do_read(8'h20, 16'h1234, 16'h1234);

        for (int i = 0; i < 8; i++) do_write(8'(i), 2'b11, 16'(16'h1000 + i));
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("burst_valid_a", rd_valid_a, 1'b1);
                check("burst_data_a", rd_data_a, 32'(16'h1000 + i - 1));
            end
            rd_en   = (i < 8);
            rd_addr = 8'(i);
        end
        repeat (3) @(negedge clk);

`ifdef RAM_PARITY_EN
        @(negedge clk);
        dut_a.r_mem[48] = dut_a.r_mem[48] ^ 16'h0001;
        dut_b.r_mem[48] = dut_b.r_mem[48] ^ 16'h0001;
        m_mem[48] = m_mem[48] ^ 16'h0001;
        m_bad[48] = 2'b01;
        do_read(8'h30, 16'hFFFE, 16'hFFFE);
        check("par_err_set_a", par_err_a, 1'b1);
        repeat (3) @(negedge clk);
        check("par_err_held_a", par_err_a, 1'b1);
`endif

        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 8'h10; wr_be = 2'b11; wr_data = 16'h0000;
        rd_en = 1'b1; rd_addr = 8'h10;
        cnt = 0;
        while (busy_a && cnt < 1000) begin
            cnt++;
            check("no_valid_busy", rd_valid_a | rd_valid_b, 1'b0);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("clear_len_req", cnt, 256);
        do_read(8'h10, 16'hFFFF, 16'hFFFF);
        do_read(8'h03, 16'hFFFF, 16'hFFFF);
`ifdef RAM_PARITY_EN
        check("par_err_cleared_a", par_err_a, 1'b0);
`endif

        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (99) @(negedge clk);
        reset_count(cnt);
        check("clear_len_rst_mid", cnt, 256);
        do_read(8'h20, 16'hFFFF, 16'hFFFF);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
